jk_reg_bank: RTL
================

Name: jk_reg_bank

Overview:
Parametrised bank of WIDTH edge-triggered JK flip-flops sharing one clock. It generalises the single-bit level-sensitive jk_latch into an edge-triggered register. Adds selectable per-bank modes (JK, D, T, hold), parallel load, and change detection with a saturating change-event counter. Used as a general control/status register primitive in lab datapaths.

Parameters:
WIDTH, 4, number of flip-flop bits in the bank (1..32)
RESET_VAL, 0, value of q after reset (WIDTH bits)
CNT_W, 8, width of change-event counter chg_cnt

Ports:
ck  input  1  clock, rising-edge active
rst  input  1  asynchronous active-high reset
en  input  1  update enable for mode-driven update
mode  input  2  00 JK, 01 D (j is data), 10 T (j is toggle mask), 11 hold
j  input  WIDTH  per-bit J / D / T input
k  input  WIDTH  per-bit K input (used in JK mode only)
load  input  1  synchronous parallel load strobe
load_data  input  WIDTH  value written on load
clr_cnt  input  1  synchronous clear of chg_cnt
q  output  WIDTH  register state
q_n  output  WIDTH  complement of q
changed  output  1  one-cycle flag: q changed at the last edge
chg_cnt  output  CNT_W  saturating count of edges where q changed

Behaviour:
- One clock ck; reset is asynchronous and active-high. Clock port is named ck, reset port is named rst.
- Reset values:
  - q = RESET_VAL, q_n = ~RESET_VAL
  - changed = 0, chg_cnt = 0
  - rst asserted mid-operation clears immediately, without waiting for an edge.
- q_n is combinationally ~q at all times; it is never independently registered.
- Update priority at each rising ck: rst > load > en > hold.
- load=1: q <= load_data, regardless of en and mode.
- load=0, en=1: each bit i is updated according to mode:
  - JK (00): j=0,k=0 hold; j=1,k=0 set; j=0,k=1 clear; j=1,k=1 toggle.
  - D (01): q[i] <= j[i]; k is ignored.
  - T (10): q[i] <= q[i] ^ j[i]; k is ignored.
  - hold (11): no change.
- load=0, en=0: q holds.
- Latency: one edge. The new q is visible after the edge in which the inputs were sampled.
- changed <= (q_next != q), registered on the same edge that q updates:
  - It is high for exactly the cycle following a differing update.
  - A load of the value already held gives changed=0.
- chg_cnt:
  - Increments by 1 on each edge where q_next != q.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 forces chg_cnt <= 0 on that edge, even if a change occurs on the same edge (clear wins).
  - clr_cnt does not affect q or changed.
- No combinational path from any input to q, changed or chg_cnt.
- The race state of the latch (j=k=1 with level clock) does not exist; JK toggle occurs once per edge.

Test Plan:
- Reset: set rst=1 mid-cycle with q=4'hA. Required: q=0 and q_n=4'hF immediately (asynchronous); changed=0 and chg_cnt=0; values hold until rst=0.
- JK mode, WIDTH=4, q=4'b0000, en=1: apply j=4'b1010,k=4'b0000 -> q=4'b1010, changed=1, chg_cnt=1. Then j=4'b0011,k=4'b0110 -> q=4'b1001 (bit1 toggle, bit2 clear, bit0 set, bit3 hold), chg_cnt=2. Then j=k=4'b0000 -> q=4'b1001, changed=0, chg_cnt=2.
- Modes: from q=4'b1001, mode=10, j=4'b1111 -> q=4'b0110. Then mode=01, j=4'b0011 -> q=4'b0011. Then mode=11, any j/k -> q=4'b0011 and changed=0. Then en=0 with mode=00 and j=k=4'b1111 -> q unchanged.
- Load priority: load=1, load_data=4'h5, en=1, mode=00, j=k=4'hF -> q=4'h5. Then load=1, load_data=4'h5 again -> changed=0 and chg_cnt unchanged.
- Counter saturation and clear, CNT_W=3: toggle every cycle (mode=10, j=4'h1) for 10 edges -> chg_cnt stops at 7. Assert clr_cnt on an edge with a toggle -> chg_cnt=0 and changed=1. Next toggle -> chg_cnt=1.
- Parametrisation: WIDTH=1 and WIDTH=32 with RESET_VAL=all ones: after reset q=all ones and q_n=0. A JK toggle with all j=k=1 gives q=0 and chg_cnt=1.

Source files
------------

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - edge-triggered JK register bank with D/T/hold modes, parallel load and change counter
module jk_reg_bank #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_D    = 2'b01;
  localparam logic [1:0] MODE_T    = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic             q_diff;

  assign q_n = ~q;

  // Priority: load beats the mode-driven update, which needs en.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_data;
    end else if (en) begin
      case (mode)
        MODE_JK:   q_next = (j & ~q) | (~k & q);
        MODE_D:    q_next = j;
        MODE_T:    q_next = q ^ j;
        MODE_HOLD: q_next = q;
        default:   q_next = q;
      endcase
    end
  end

  assign q_diff = (q_next != q);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
      chg_cnt <= '0;
    end else begin
      q       <= q_next;
      changed <= q_diff;
      // Clear wins over a simultaneous change; the count saturates instead of wrapping.
      if (clr_cnt) begin
        chg_cnt <= '0;
      end else if (q_diff && (chg_cnt != CNT_MAX)) begin
        chg_cnt <= chg_cnt + CNT_ONE;
      end
    end
  end

endmodule
